// File: rtl/vector_cache_pkg.sv
// Shared vector-cache types: direction ids, the data beat payload and the
// egress buffer constants/status struct.
`ifndef VEC_CACHE_WEST
`define VEC_CACHE_WEST  2'd0
`define VEC_CACHE_EAST  2'd1
`define VEC_CACHE_NORTH 2'd2
`define VEC_CACHE_SOUTH 2'd3
`endif

package vector_cache_pkg;

    localparam int VEC_CH_NUM            = 8;
    localparam int VEC_EGRESS_FIFO_DEPTH = 4;

    localparam logic [1:0] DIR_WEST  = 2'd0;
    localparam logic [1:0] DIR_EAST  = 2'd1;
    localparam logic [1:0] DIR_NORTH = 2'd2;
    localparam logic [1:0] DIR_SOUTH = 2'd3;

    typedef struct packed {
        logic [1:0] direction_id;
        logic [5:0] rob_id;
    } txn_id_t;

    typedef struct packed {
        txn_id_t    txn_id;
        logic [3:0] opcode;
    } cmd_pld_t;

    typedef struct packed {
        cmd_pld_t    cmd_pld;
        logic [31:0] data;
    } data_pld_t;

    typedef struct packed {
        logic [VEC_CH_NUM-1:0] ovf_err;
        logic [VEC_CH_NUM-1:0] dir_err;
    } egress_status_t;

endpackage

// File: rtl/vec_cache_egress_fifo.sv
// Single-channel show-ahead FIFO: head is the oldest entry, valid whenever
// the FIFO is non-empty. The caller guarantees no push into a full FIFO
// unless it pops in the same cycle.
module vec_cache_egress_fifo
    import vector_cache_pkg::*;
#(
    parameter int  DEPTH = VEC_EGRESS_FIFO_DEPTH,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  data_pld_t     wdata,
    output data_pld_t     head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    data_pld_t         mem [DEPTH];
    logic     [PW-1:0] wr_ptr;
    logic     [PW-1:0] rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/vec_cache_data_egress_buf.sv
// Captures per-channel beats from one switch edge, buffers each channel in its
// own FIFO and merges them round-robin onto a single valid/ready port.
module vec_cache_data_egress_buf
    import vector_cache_pkg::*;
#(
    parameter int         CH_NUM     = VEC_CH_NUM,
    parameter int         FIFO_DEPTH = VEC_EGRESS_FIFO_DEPTH,
    parameter logic [1:0] DIR_ID     = `VEC_CACHE_WEST
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CH_NUM-1:0] in_vld,
    input  data_pld_t         in_pld [CH_NUM],
    output logic              out_vld,
    output data_pld_t         out_pld,
    output logic [2:0]        out_ch,
    input  logic              out_rdy,
    output logic [CH_NUM-1:0] credit_rtn,
    output logic [CH_NUM-1:0] ovf_err,
    output logic [CH_NUM-1:0] dir_err
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // Output handshake: a beat transfers on a cycle where out_vld && out_rdy.
    // Once out_vld is raised, out_ch/out_pld hold until that transfer.
    data_pld_t         head [CH_NUM];
    logic [CH_NUM-1:0] full;
    logic [CH_NUM-1:0] empty;
    logic [CW-1:0]     occ  [CH_NUM];
    logic [CH_NUM-1:0] push;
    logic [CH_NUM-1:0] pop;
    logic [CH_NUM-1:0] drop;
    logic [CH_NUM-1:0] bad_dir;

    logic              lock_vld;
    logic [2:0]        lock_ch;
    logic [2:0]        rr_ptr;
    egress_status_t    status;

    logic              found;
    logic [2:0]        srch_ch;
    logic [2:0]        idx;
    logic [2:0]        grant_ch;
    logic              hs;

    always_comb begin
        found   = 1'b0;
        srch_ch = '0;
        idx     = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            idx = rr_ptr + 3'(k);
            if (!found && !empty[idx]) begin
                found   = 1'b1;
                srch_ch = idx;
            end
        end
    end

    // A held grant overrides the search so the presented beat cannot change.
    assign grant_ch = lock_vld ? lock_ch : srch_ch;
    assign out_vld  = lock_vld | found;
    assign out_ch   = out_vld ? grant_ch : 3'd0;
    assign out_pld  = out_vld ? head[grant_ch] : '0;
    assign hs       = out_vld & out_rdy;

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        assign pop[i]     = hs && (grant_ch == 3'(i));
        assign push[i]    = in_vld[i] && (!full[i] || pop[i]);
        assign drop[i]    = in_vld[i] && (occ[i] == CW'(FIFO_DEPTH)) && !pop[i];
        assign bad_dir[i] = in_vld[i] && (in_pld[i].cmd_pld.txn_id.direction_id != DIR_ID);

        vec_cache_egress_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[i]),
            .pop   (pop[i]),
            .wdata (in_pld[i]),
            .head  (head[i]),
            .full  (full[i]),
            .empty (empty[i]),
            .count (occ[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_vld   <= 1'b0;
            lock_ch    <= '0;
            rr_ptr     <= '0;
            credit_rtn <= '0;
            status     <= '0;
        end else begin
            credit_rtn <= pop;
            if (hs) begin
                lock_vld <= 1'b0;
                rr_ptr   <= grant_ch + 3'd1;  // eight channels: 3-bit wrap is mod CH_NUM
            end else if (out_vld) begin
                lock_vld <= 1'b1;
                lock_ch  <= grant_ch;
            end
            status.ovf_err <= status.ovf_err | drop;
            status.dir_err <= status.dir_err | bad_dir;
        end
    end

    assign ovf_err = status.ovf_err;
    assign dir_err = status.dir_err;

endmodule

// File: tb/tb_vec_cache_data_egress_buf.sv
// Bench for the egress buffer: directed scenarios plus random traffic, checked
// against a queue-based model of the per-channel FIFOs and round-robin merge.
module tb_vec_cache_data_egress_buf;
    import vector_cache_pkg::*;

    localparam int CH    = 8;
    localparam int DEPTH = 4;
    localparam int PW    = $bits(data_pld_t);
    localparam logic [1:0] DIR = DIR_WEST;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CH-1:0] in_vld = '0;
    data_pld_t     in_pld [CH];
    logic          out_vld;
    data_pld_t     out_pld;
    logic [2:0]    out_ch;
    logic          out_rdy = 1'b0;
    logic [CH-1:0] credit_rtn;
    logic [CH-1:0] ovf_err;
    logic [CH-1:0] dir_err;

    always #5 clk = ~clk;

    vec_cache_data_egress_buf #(.CH_NUM(CH), .FIFO_DEPTH(DEPTH), .DIR_ID(DIR)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_vld     (in_vld),
        .in_pld     (in_pld),
        .out_vld    (out_vld),
        .out_pld    (out_pld),
        .out_ch     (out_ch),
        .out_rdy    (out_rdy),
        .credit_rtn (credit_rtn),
        .ovf_err    (ovf_err),
        .dir_err    (dir_err)
    );

    // Reference model state
    logic [PW-1:0] exp_q [CH][$];
    int            m_rr;
    bit            m_lock;
    int            m_lock_ch;
    logic [CH-1:0] m_credit;
    logic [CH-1:0] m_ovf;
    logic [CH-1:0] m_dir;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) exp_q[i].delete();
        m_rr      = 0;
        m_lock    = 0;
        m_lock_ch = 0;
        m_credit  = '0;
        m_ovf     = '0;
        m_dir     = '0;
    endtask

    // Channel the merged port should be presenting, or -1 when idle.
    function automatic int exp_grant();
        if (m_lock) return m_lock_ch;
        for (int k = 0; k < CH; k++) begin
            if (exp_q[(m_rr + k) % CH].size() != 0) return (m_rr + k) % CH;
        end
        return -1;
    endfunction

    task automatic compare_outputs();
        int g;
        g = exp_grant();
        check_eq("out_vld", out_vld, (g >= 0) ? 64'd1 : 64'd0);
        if (g >= 0) begin
            check_eq("out_ch", out_ch, 64'(g));
            check_eq("out_pld", out_pld, 64'(exp_q[g][0]));
        end
        check_eq("credit_rtn", credit_rtn, m_credit);
        check_eq("ovf_err", ovf_err, m_ovf);
        check_eq("dir_err", dir_err, m_dir);
    endtask

    // Advance the model across one rising edge using the inputs just applied.
    task automatic model_step();
        int            g;
        bit            hs;
        logic [CH-1:0] accept;
        g        = exp_grant();
        hs       = (g >= 0) && out_rdy;
        m_credit = hs ? CH'(1 << g) : '0;
        accept   = '0;
        for (int i = 0; i < CH; i++) begin
            if (in_vld[i]) begin
                if (in_pld[i].cmd_pld.txn_id.direction_id != DIR) m_dir[i] = 1'b1;
                if (exp_q[i].size() == DEPTH && !(hs && g == i)) m_ovf[i] = 1'b1;
                else accept[i] = 1'b1;
            end
        end
        if (hs) begin
            void'(exp_q[g].pop_front());
            m_rr   = (g + 1) % CH;
            m_lock = 0;
        end else if (g >= 0) begin
            m_lock    = 1;
            m_lock_ch = g;
        end
        for (int i = 0; i < CH; i++) begin
            if (accept[i]) exp_q[i].push_back(in_pld[i]);
        end
    endtask

    // dir_mode < 0: mostly DIR with the odd random direction.
    task automatic drive_cycle(input logic [CH-1:0] vld, input logic rdy, input int dir_mode);
        data_pld_t p;
        @(negedge clk);
        for (int i = 0; i < CH; i++) begin
            p.data                      = $urandom;
            p.cmd_pld.opcode            = 4'($urandom);
            p.cmd_pld.txn_id.rob_id     = 6'($urandom);
            if (dir_mode < 0)
                p.cmd_pld.txn_id.direction_id = ($urandom_range(0, 15) == 0) ? 2'($urandom) : DIR;
            else
                p.cmd_pld.txn_id.direction_id = 2'(dir_mode);
            in_pld[i] = p;
        end
        in_vld  = vld;
        out_rdy = rdy;
        #1 compare_outputs();
        @(posedge clk);
        model_step();
    endtask

    // Asserts reset mid-cycle so the async clear is visible before any edge.
    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_out_vld", out_vld, 0);
        check_eq("rst_out_ch", out_ch, 0);
        check_eq("rst_out_pld", out_pld, 0);
        check_eq("rst_credit", credit_rtn, 0);
        check_eq("rst_ovf", ovf_err, 0);
        check_eq("rst_dir", dir_err, 0);
        model_reset();
        in_vld  = '0;
        out_rdy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < CH; i++) in_pld[i] = '0;
        model_reset();

        // Single beat on ch2
        do_reset();
        drive_cycle(8'h04, 1'b1, DIR);
        drive_cycle(8'h00, 1'b1, DIR);
        #1 check_eq("single_credit", credit_rtn, 8'h04);
        drive_cycle(8'h00, 1'b1, DIR);

        // Fairness across ch0, ch3, ch7
        do_reset();
        drive_cycle(8'h89, 1'b0, DIR);
        drive_cycle(8'h89, 1'b0, DIR);
        for (int i = 0; i < 8; i++) drive_cycle(8'h00, 1'b1, DIR);

        // Stall lock: ch5 held while ch1 fills
        do_reset();
        drive_cycle(8'h20, 1'b0, DIR);
        drive_cycle(8'h00, 1'b0, DIR);
        drive_cycle(8'h02, 1'b0, DIR);
        #1 check_eq("stall_ch", out_ch, 5);
        drive_cycle(8'h00, 1'b0, DIR);
        for (int i = 0; i < 3; i++) drive_cycle(8'h00, 1'b1, DIR);

        // Overflow on ch6, then drain
        do_reset();
        for (int i = 0; i < 5; i++) drive_cycle(8'h40, 1'b0, DIR);
        #1 check_eq("ovf_set", ovf_err, 8'h40);
        for (int i = 0; i < 6; i++) drive_cycle(8'h00, 1'b1, DIR);

        // Push into a full FIFO while it pops
        do_reset();
        for (int i = 0; i < 4; i++) drive_cycle(8'h40, 1'b0, DIR);
        drive_cycle(8'h40, 1'b1, DIR);
        drive_cycle(8'h00, 1'b0, DIR);
        #1 check_eq("full_pop_push_ovf", ovf_err, 8'h00);
        for (int i = 0; i < 5; i++) drive_cycle(8'h00, 1'b1, DIR);

        // Wrong direction on ch0 is flagged and still delivered
        do_reset();
        drive_cycle(8'h01, 1'b1, DIR_NORTH);
        #1 check_eq("dir_flag", dir_err, 8'h01);
        drive_cycle(8'h00, 1'b1, DIR);
        drive_cycle(8'h00, 1'b1, DIR);

        // Reset with beats buffered and a grant locked
        do_reset();
        for (int i = 0; i < 3; i++) drive_cycle(8'h04, 1'b0, DIR);
        do_reset();
        for (int i = 0; i < 4; i++) drive_cycle(8'h00, 1'b1, DIR);

        // Random traffic, with one reset partway through
        for (int n = 0; n < 800; n++) begin
            if (n == 400) do_reset();
            drive_cycle(CH'($urandom_range(0, 255) & $urandom_range(0, 255)),
                        ($urandom_range(0, 9) < 7), -1);
        end
        for (int i = 0; i < 40; i++) drive_cycle(8'h00, 1'b1, DIR);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vec_cache_data_egress_buf.md
Name: vec_cache_data_egress_buf

Overview:
- Downstream of the diagonal-block XY switch. It captures the per-channel data beats the switch emits on one edge (west, north or south) as valid-only pulses with no backpressure.
- Buffers each of the 8 channels in its own FIFO, then merges them round-robin onto a single valid/ready requester port.
- Returns one credit per dequeued beat so upstream issue logic can throttle and never overrun a FIFO.

Parameters:
- CH_NUM, 8, number of data channels (fixed by the switch width).
- FIFO_DEPTH, 4, entries per channel FIFO; power of two, at least 2.
- DIR_ID, `VEC_CACHE_WEST, the direction this instance serves; used only for checking.

Ports:
- clk  input  1  core clock.
- rst_n  input  1  asynchronous reset, active-low.
- in_vld  input  CH_NUM  per-channel beat valid from the switch edge output; no ready is returned.
- in_pld  input  data_pld_t [CH_NUM]  per-channel beat payload.
- out_vld  output  1  merged beat valid.
- out_pld  output  data_pld_t  merged beat payload.
- out_ch  output  3  channel index of the current out_pld.
- out_rdy  input  1  requester accepts the beat.
- credit_rtn  output  CH_NUM  one-cycle pulse per channel, one credit per dequeued entry.
- ovf_err  output  CH_NUM  sticky per-channel overflow flag.
- dir_err  output  CH_NUM  sticky per-channel flag: a beat arrived whose direction_id differs from DIR_ID.

Behaviour:
- Reset (async assert, sync deassert): all FIFOs empty, read/write pointers 0, round-robin pointer 0 (channel 0 has highest priority), grant lock cleared. Outputs: out_vld=0, out_pld=0, out_ch=0, credit_rtn=0, ovf_err=0, dir_err=0.
- Push:
  - in_vld[i]=1 and FIFO i not full: write in_pld[i] at wr_ptr, wr_ptr wraps modulo FIFO_DEPTH.
  - FIFO full and no pop of i this cycle: drop the beat and set ovf_err[i].
  - FIFO full with a simultaneous pop of i: accept the push, no error.
- Direction check: any accepted or dropped beat with in_pld[i].cmd_pld.txn_id.direction_id != DIR_ID sets dir_err[i]. The beat is still stored.
- Occupancy: count per FIFO, width clog2(FIFO_DEPTH)+1. full = count==FIFO_DEPTH, empty = count==0.
- Latency: a beat pushed at edge N can appear on out_vld in cycle N+1 at the earliest. Show-ahead FIFO; output is combinational from the FIFO head plus the arbiter.
- Arbitration:
  - Round-robin among non-empty FIFOs, search starting at rr_ptr.
  - out_vld=1 when any FIFO is non-empty (or the lock is held). out_ch and out_pld come from the granted head.
  - Grant lock: if out_vld=1 and out_rdy=0, the grant is registered. out_ch and out_pld must stay stable until the handshake, even if a higher-priority FIFO fills meanwhile.
  - Handshake (out_vld && out_rdy): pop FIFO out_ch, set rr_ptr = out_ch+1 mod CH_NUM, release the lock.
- Credit: credit_rtn[out_ch] is registered and pulses in the cycle after the handshake. At most one bit is set per cycle.
- Simultaneous push and pop on the same FIFO: count unchanged.
- Sticky flags clear only on rst_n.
- Reset mid-operation drops all buffered beats. No credits are returned for dropped beats; upstream credit counters are reset by the same rst_n.

Decomposition:
- vector_cache_pkg additions: VEC_EGRESS_FIFO_DEPTH constant, and an egress_status_t struct (ovf_err, dir_err).
- data_pld_t and the direction defines are reused unchanged.
- Sub-module vec_cache_egress_fifo: one synchronous show-ahead FIFO with push, pop, head, full, empty and count. Instantiated CH_NUM times.
- The arbiter, lock, credit and checks stay in the top module.

Test Plan:
- Single beat: in_vld=8'h04 for one cycle with out_rdy=1 → out_vld=1 next cycle with out_ch=2. credit_rtn=8'h04 the cycle after that. rr_ptr=3.
- Fairness: preload 2 beats each in ch0, ch3 and ch7 with out_rdy=1 → out_ch order 0,3,7,0,3,7 and 6 credit pulses.
- Stall lock: ch5 head presented, out_rdy=0. Push into ch1 while rr_ptr=0 → out_ch stays 5 with out_pld unchanged. On out_rdy=1, ch5 pops, then ch1 is served.
- Overflow: FIFO_DEPTH=4, out_rdy=0, 5 pushes on ch6 → ovf_err=8'h40 and the 5th beat is lost. On drain, exactly 4 beats appear. Push on a full FIFO in the same cycle as its pop → no error.
- Direction check: DIR_ID=west, beat on ch0 with direction_id=north → dir_err[0]=1, beat still delivered.
- Reset mid-operation: 3 beats buffered in ch2 and a stall lock held, assert rst_n low asynchronously → out_vld=0 immediately. After release, no stale beats and no credits.
